// File: rtl/seg7_bcd_reader.sv
// seg7_bcd_reader: recovers per-digit BCD from a muxed active-low 7-seg bus; define SEG7_READER_DP_EN to add decimal-point capture
module seg7_bcd_reader #(
  parameter int NUM_DIGITS = 6,
  parameter int STABLE_CNT = 4
) (
  input  logic                    seg7_clk,
  input  logic                    seg7_rst_n,
  input  logic [6:0]              seg7_seg_in,
  input  logic [NUM_DIGITS-1:0]   seg7_sel_in,
  input  logic                    seg7_sample_in,
  input  logic                    seg7_clr_in,
`ifdef SEG7_READER_DP_EN
  input  logic                    seg7_dp_in,
  output logic [NUM_DIGITS-1:0]   seg7_dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] seg7_digits_out,
  output logic [NUM_DIGITS-1:0]   seg7_valid_out,
  output logic                    seg7_err_out,
  output logic                    seg7_frame_out
);
  localparam logic [3:0] SC = 4'(STABLE_CNT);
  logic [6:0] seg_r, ref_seg;
  logic [NUM_DIGITS-1:0] sel_r, ref_sel, hit, seen, seen_nxt;
  logic stb_r, ref_ok, dp_w, dp_r, ref_dp, sel_ok, match, commit, legal, blank;
  logic [3:0] count, count_nxt, bcd;
`ifdef SEG7_READER_DP_EN
  assign dp_w = seg7_dp_in;
`else
  assign dp_w = 1'b1;
`endif
  // capture the display bus and strobe together so all decisions see one coherent sample
  always_ff @(posedge seg7_clk or negedge seg7_rst_n)
    if (!seg7_rst_n) begin
      seg_r <= 7'h7F;
      sel_r <= '1;
      stb_r <= 1'b0;
      dp_r  <= 1'b1;
    end else begin
      seg_r <= seg7_seg_in;
      sel_r <= seg7_sel_in;
      stb_r <= seg7_sample_in;
      dp_r  <= dp_w;
    end
  // segment pattern to BCD; 4'hF marks anything that is not a decimal digit
  always_comb begin
    bcd = 4'hF;
    case (seg_r)
      7'h40: bcd = 4'd0;
      7'h79: bcd = 4'd1;
      7'h24: bcd = 4'd2;
      7'h30: bcd = 4'd3;
      7'h19: bcd = 4'd4;
      7'h12: bcd = 4'd5;
      7'h02: bcd = 4'd6;
      7'h78: bcd = 4'd7;
      7'h00: bcd = 4'd8;
      7'h10: bcd = 4'd9;
      default: bcd = 4'hF;
    endcase
  end
  // stability run tracking and commit decision; a commit fires only on the edge the run reaches STABLE_CNT
  always_comb begin
    sel_ok    = $onehot(~sel_r);
    match     = ref_ok && sel_r == ref_sel && seg_r == ref_seg && dp_r == ref_dp;
    count_nxt = !match ? 4'd1 : count == SC ? count : count + 4'd1;
    commit    = stb_r && sel_ok && count_nxt == SC && (!match || count != SC);
    hit       = commit ? ~sel_r : '0;
    blank     = seg_r == 7'h7F;
    legal     = bcd != 4'hF;
    seen_nxt  = seen | (legal ? hit : '0);
  end
  // reference sample and run length; clear and illegal selects restart the run
  always_ff @(posedge seg7_clk or negedge seg7_rst_n)
    if (!seg7_rst_n) begin
      count   <= 4'd0;
      ref_ok  <= 1'b0;
      ref_sel <= '1;
      ref_seg <= 7'h7F;
      ref_dp  <= 1'b1;
    end else if (seg7_clr_in) begin
      count  <= 4'd0;
      ref_ok <= 1'b0;
    end else if (stb_r) begin
      count   <= sel_ok ? count_nxt : 4'd0;
      ref_ok  <= sel_ok;
      ref_sel <= sel_r;
      ref_seg <= seg_r;
      ref_dp  <= dp_r;
    end
  // committed digit values, validity, sticky error and frame completion pulse
  always_ff @(posedge seg7_clk or negedge seg7_rst_n)
    if (!seg7_rst_n) begin
      seg7_digits_out <= '1;
      seg7_valid_out  <= '0;
      seg7_err_out    <= 1'b0;
      seg7_frame_out  <= 1'b0;
      seen            <= '0;
    end else if (seg7_clr_in) begin
      seg7_valid_out <= '0;
      seg7_err_out   <= 1'b0;
      seg7_frame_out <= 1'b0;
      seen           <= '0;
    end else begin
      seg7_frame_out <= commit && &seen_nxt;
      seen           <= commit && &seen_nxt ? '0 : seen_nxt;
      seg7_valid_out <= (seg7_valid_out & ~hit) | (legal ? hit : '0);
      seg7_err_out   <= seg7_err_out | (commit && !legal && !blank);
      for (int i = 0; i < NUM_DIGITS; i++)
        if (hit[i]) seg7_digits_out[4*i +: 4] <= bcd;
    end
`ifdef SEG7_READER_DP_EN
  // decimal point follows every commit of its digit
  always_ff @(posedge seg7_clk or negedge seg7_rst_n)
    if (!seg7_rst_n) seg7_dp_out <= '0;
    else if (!seg7_clr_in)
      for (int i = 0; i < NUM_DIGITS; i++)
        if (hit[i]) seg7_dp_out[i] <= ~dp_r;
`endif
endmodule
